// File: rtl/rv_pkg.sv
// Shared fetch/decode constants: canonical NOP encoding and default datapath widths.
package rv_pkg;
  localparam int          RV_ADDRESS_BITS = 16;
  localparam int          RV_DATA_WIDTH   = 32;
  localparam logic [31:0] NOP             = 32'h0000_0013;  // addi x0,x0,0
endpackage

// File: rtl/ibuf_storage.sv
// Entry array for the instruction buffer: one synchronous write port, one combinational read port.
module ibuf_storage #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [PW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  // Contents are deliberately not reset; occupancy is tracked by the owner.
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instruction_buffer.sv
// Fetch-to-decode decoupling FIFO of {PC, instruction} pairs with first-word-fall-through head.
module instruction_buffer
  import rv_pkg::*;
#(
  parameter int ADDRESS_BITS = RV_ADDRESS_BITS,
  parameter int DATA_WIDTH   = RV_DATA_WIDTH,
  parameter int DEPTH        = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [ADDRESS_BITS-1:0]    in_pc,
  input  logic [DATA_WIDTH-1:0]      in_instruction,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [ADDRESS_BITS-1:0]    out_pc,
  output logic [DATA_WIDTH-1:0]      out_instruction,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDRESS_BITS + DATA_WIDTH;

  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      push, pop;
  logic [EW-1:0]             head;
  logic [ADDRESS_BITS-1:0]   head_pc;
  logic [DATA_WIDTH-1:0]     head_ins;

  // in_ready depends on occupancy only, so a full buffer never accepts even when popping.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A flushed push is never written, keeping storage writes aligned with pointer moves.
  ibuf_storage #(.WIDTH(EW), .DEPTH(DEPTH), .PW(PW)) u_storage (
    .clock   (clock),
    .we_i    (push & ~flush),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_pc, in_instruction}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign {head_pc, head_ins} = head;
  assign out_pc          = out_valid ? head_pc  : '0;
  assign out_instruction = out_valid ? head_ins : DATA_WIDTH'(NOP);
endmodule

// File: tb/tb_instruction_buffer.sv
// Directed bench with a queue scoreboard modelling the expected FIFO contents.
module tb_instruction_buffer;
  import rv_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [15:0] in_pc;
  logic [31:0] in_instruction;
  logic        in_ready, out_valid;
  logic [15:0] out_pc;
  logic [31:0] out_instruction;
  logic [2:0]  count;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  instruction_buffer #(.ADDRESS_BITS(16), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_pc           (in_pc),
    .in_instruction  (in_instruction),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instruction (out_instruction),
    .out_ready       (out_ready),
    .count           (count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares every output against the scoreboard head and occupancy.
  task automatic check_state(input string tag);
    int n = sb.size();
    chk({tag, ".count"},     64'(count),     64'(n));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(n != DEPTH));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(n != 0));
    chk({tag, ".out_pc"},    64'(out_pc),    (n != 0) ? 64'(sb[0].pc)  : 64'(0));
    chk({tag, ".out_ins"},   64'(out_instruction), (n != 0) ? 64'(sb[0].ins) : 64'(NOP));
  endtask

  // Drive one cycle at the falling edge, check the settled outputs, then update the model at the rising edge.
  task automatic step(input string tag, input logic v, input logic [15:0] pc,
                      input logic rdy, input logic fl);
    logic push, pop;
    logic [31:0] ins;
    ins            = {16'h0050, pc} ^ 32'h0000_0093;
    in_valid       = v;
    in_pc          = pc;
    in_instruction = ins;
    out_ready      = rdy;
    flush          = fl;
    #1;
    check_state(tag);
    push = v && (sb.size() != DEPTH);
    pop  = rdy && (sb.size() != 0);
    @(posedge clock);
    if (fl) sb.delete();
    else begin
      if (pop)  void'(sb.pop_front());
      if (push) sb.push_back('{pc, ins});
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_pc = 16'h1234; in_instruction = 32'hDEAD_BEEF;
    repeat (2) @(posedge clock);
    @(negedge clock);
    // Reset held with in_valid asserted: nothing may be captured.
    chk("rst.count",     64'(count),           64'(0));
    chk("rst.out_valid", 64'(out_valid),       64'(0));
    chk("rst.in_ready",  64'(in_ready),        64'(1));
    chk("rst.out_ins",   64'(out_instruction), 64'h0000_0013);
    chk("rst.out_pc",    64'(out_pc),          64'(0));
    in_valid = 1'b0;
    reset    = 1'b1;
    step("rel", 1'b0, 16'h0000, 1'b0, 1'b0);
    check_state("rel.after");
    chk("rel.count0", 64'(count), 64'(0));

    // Single pass: in_instruction derived so pc 0000 gives 00500093.
    step("sp.push", 1'b1, 16'h0000, 1'b0, 1'b0);
    in_valid = 1'b0; #1;
    chk("sp.out_valid", 64'(out_valid),       64'(1));
    chk("sp.out_pc",    64'(out_pc),          64'(16'h0000));
    chk("sp.out_ins",   64'(out_instruction), 64'h0050_0093);
    chk("sp.count",     64'(count),           64'(1));
    step("sp.drain", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Fill to DEPTH, try a fifth push, then drain in order.
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 16'(i * 4), 1'b0, 1'b0);
    #1;
    chk("fill.count",    64'(count),    64'(4));
    chk("fill.in_ready", 64'(in_ready), 64'(0));
    step("fill.5th", 1'b1, 16'h0010, 1'b0, 1'b0);
    chk("fill.5th.count", 64'(count), 64'(4));
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain.order", 64'(out_pc), 64'(i * 4));
      step("drain", 1'b0, 16'h0000, 1'b1, 1'b0);
    end
    #1;
    chk("drain.empty", 64'(out_valid), 64'(0));
    step("empty.pop", 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("empty.nounderflow", 64'(count), 64'(0));

    // Simultaneous push/pop at count 2 across pointer wrap.
    step("sim.pre", 1'b1, 16'h0100, 1'b0, 1'b0);
    step("sim.pre", 1'b1, 16'h0104, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("sim.order", 64'(out_pc), 64'(16'h0100 + 16'(i * 4)));
      step("sim", 1'b1, 16'h0108 + 16'(i * 4), 1'b1, 1'b0);
    end
    chk("sim.count", 64'(count), 64'(2));

    // Full + pop: only the pop happens.
    step("fp.fill", 1'b1, 16'h0200, 1'b0, 1'b0);
    step("fp.fill", 1'b1, 16'h0204, 1'b0, 1'b0);
    chk("fp.full", 64'(count), 64'(4));
    step("fp.pop", 1'b1, 16'h0208, 1'b1, 1'b0);
    chk("fp.count3", 64'(count),    64'(3));
    chk("fp.ready",  64'(in_ready), 64'(1));

    // Flush at count 3 with a concurrent push and pop.
    step("fl", 1'b1, 16'h0010, 1'b1, 1'b1);
    chk("fl.count",     64'(count),     64'(0));
    chk("fl.out_valid", 64'(out_valid), 64'(0));
    step("fl.push", 1'b1, 16'h0010, 1'b0, 1'b0);
    in_valid = 1'b0; #1;
    chk("fl.out_pc", 64'(out_pc), 64'(16'h0010));

    // Async reset mid-stream: empty before any further clock edge.
    step("ar.push", 1'b1, 16'h0014, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    sb.delete();
    chk("ar.count",     64'(count),     64'(0));
    chk("ar.out_valid", 64'(out_valid), 64'(0));
    chk("ar.in_ready",  64'(in_ready),  64'(1));
    @(negedge clock);
    reset = 1'b1;
    step("ar.after", 1'b1, 16'h0020, 1'b0, 1'b0);
    check_state("ar.final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
